lane_rotator_pipe: RTL
======================

// Module: lane_rotator_pipe
// PURPOSE
//   Pipelined, parametrised lane rotator/shifter: moves N lanes of W bits by a per-transaction
//   lane amount through log2(N) registered butterfly stages (stage k moves by 2^k lanes).
//   Supports rotate and zero-fill shift in both directions, with a valid/ready handshake
//   on both sides. Sits between lane-packed datapaths (alignment, permutation front-ends)
//   and generalises the single-level registered mux array to a full streaming rotator.
// PARAMETERS
//   N      8   number of lanes; power of two, >= 2
//   W      8   bits per lane
//   AW     $clog2(N)  amount width and stage count (derived; do not override)
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low reset (0 = in reset)
//   in_valid   in   1      input transaction valid
//   in_ready   out  1      block can accept an input this cycle
//   in_data    in   N*W    lane i = in_data[i*W +: W]
//   in_amt     in   AW     lane move amount, 0..N-1
//   in_mode    in   2      bit0: dir (0 = down, 1 = up); bit1: fill (0 = rotate, 1 = zero-fill shift)
//   out_valid  out  1      output transaction valid
//   out_ready  in   1      downstream accepts output this cycle
//   out_data   out  N*W    result lanes, same packing as in_data
// BEHAVIOUR
//   - Function: down: out lane i = in lane (i+amt); up: out lane i = in lane (i-amt).
//     Rotate wraps the index mod N. Shift yields 0 where the source index leaves 0..N-1.
//   - Stage k (k = 0..AW-1) applies a 2^k move iff the carried amt bit k = 1. Each stage
//     registers data, the remaining amt bits, mode and a valid bit.
//   - Latency: exactly AW cycles from an accepted input to out_valid, with no stall.
//     Throughput: 1 transaction/cycle.
//   - Handshake: accept when in_valid && in_ready; deliver when out_valid && out_ready.
//     advance = !out_valid || out_ready. in_ready = advance, combinational.
//     All stages load together when advance = 1 and hold when it is 0, a global stall.
//   - A bubble (in_valid = 0 while advancing) propagates as valid = 0. Bubble data is
//     don't-care, but its registers still load so the logic stays simple.
//   - out_data and out_valid hold stable while out_valid && !out_ready.
//     Inputs may change freely while in_ready = 0; they are ignored.
//   - amt = 0: pass-through in every mode. amt >= N cannot occur, since the width is AW.
//   - Reset (reset = 0, any time including mid-stream):
//     * All stage valids go to 0 and all data, amt and mode registers go to 0.
//     * out_valid = 0, out_data = 0, and in_ready = 1 during and after reset.
//     * In-flight transactions are discarded and not replayed.
//   - Simultaneous out handshake and in accept in the same cycle is the normal full-rate
//     case: there is no loss and no duplication.
// STRUCTURE
//   - Shared package lane_rot_pkg holds:
//     * mode constants MODE_ROT_DN = 2'b00, MODE_ROT_UP = 2'b01, MODE_SHF_DN = 2'b10,
//       MODE_SHF_UP = 2'b11;
//     * the function clog2 used for AW.
//   - Sub-module lane_rot_stage #(N, W, AW, LEVEL) is one registered stage: a mux per lane
//     selecting own lane or lane (i +/- 2^LEVEL), zero-fill gating, an enable and the
//     valid/amt/mode pipe registers. The top generates AW instances and the handshake logic.
// TESTING  (N=8, W=8; input lane i = 8'h0i unless stated)
//   1. ROT_DN, amt=3, out_ready=1 -> exactly 3 cycles later out lanes 0..7 =
//      03,04,05,06,07,00,01,02.
//   2. SHF_UP, amt=5 -> out lanes 0..4 = 00, lanes 5..7 = 00,01,02.
//      SHF_DN, amt=5 -> lanes 0..2 = 05,06,07, lanes 3..7 = 00.
//   3. Stream 8 back-to-back transactions with amt = 0..7, ROT_UP -> 8 consecutive
//      out_valid cycles in order. amt=0 gives identity; amt=7 gives lane i = (i+1)%8.
//   4. out_ready=0 for 6 cycles while feeding -> in_ready=0 once 3 are in flight. out_data
//      stays stable; after release, all transactions emerge in order with none lost.
//   5. reset pulled low with 3 transactions in flight -> out_valid=0, out_data=0
//      immediately (asynchronous). After release, nothing emerges until new input;
//      in_ready=1.
//   6. Random mode/amt/data versus a reference model, 10k transactions, random
//      in_valid and out_ready -> all outputs match, in order.

Source files
------------

// File: rtl/lane_rot_pkg.sv
// Shared definitions for the pipelined lane rotator: mode encodings and a
// constant-evaluable ceil(log2) used to derive the stage count.
package lane_rot_pkg;

    localparam logic [1:0] MODE_ROT_DN = 2'b00;
    localparam logic [1:0] MODE_ROT_UP = 2'b01;
    localparam logic [1:0] MODE_SHF_DN = 2'b10;
    localparam logic [1:0] MODE_SHF_UP = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_rot_stage.sv
// One registered butterfly stage: moves all lanes by 2^LEVEL when the carried
// amount bit LEVEL is set, honouring direction and rotate/zero-fill mode.
module lane_rot_stage
    import lane_rot_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned LEVEL = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [AW-1:0]  in_amt,
    input  logic [1:0]     in_mode,
    output logic           out_valid,
    output logic [N*W-1:0] out_data,
    output logic [AW-1:0]  out_amt,
    output logic [1:0]     out_mode
);

    localparam int unsigned STEP = 32'd1 << LEVEL;

    logic           move;
    logic           dir_up;
    logic           fill;
    logic [N*W-1:0] next_data;

    assign move   = in_amt[LEVEL];
    assign dir_up = in_mode[0];
    assign fill   = in_mode[1];

    // Per-lane source select; out-of-range sources wrap for rotate, zero for shift.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] own;
        logic [W-1:0] dn_lane;
        logic [W-1:0] up_lane;

        assign own = in_data[i*W +: W];

        if (i + STEP < N) begin : g_dn_in
            assign dn_lane = in_data[(i+STEP)*W +: W];
        end else begin : g_dn_wrap
            assign dn_lane = fill ? '0 : in_data[(i+STEP-N)*W +: W];
        end

        if (i >= STEP) begin : g_up_in
            assign up_lane = in_data[(i-STEP)*W +: W];
        end else begin : g_up_wrap
            assign up_lane = fill ? '0 : in_data[(i+N-STEP)*W +: W];
        end

        assign next_data[i*W +: W] = !move ? own : (dir_up ? up_lane : dn_lane);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_mode  <= 2'b00;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= next_data;
            out_amt   <= in_amt;
            out_mode  <= in_mode;
        end
    end

endmodule

// File: rtl/lane_rotator_pipe.sv
// Streaming lane rotator/shifter: AW registered butterfly stages under a single
// global stall, valid/ready on both sides, one transaction per cycle.
module lane_rotator_pipe
    import lane_rot_pkg::*;
#(
    parameter int unsigned  N  = 8,
    parameter int unsigned  W  = 8,
    localparam int unsigned AW = clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [AW-1:0]  in_amt,
    input  logic [1:0]     in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data
);

    logic           advance;
    logic [AW:0]    vld;
    logic [N*W-1:0] dat  [AW+1];
    logic [AW-1:0]  amt  [AW+1];
    logic [1:0]     mode [AW+1];

    // Whole pipe moves only when the output slot is empty or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign vld[0]  = in_valid;
    assign dat[0]  = in_data;
    assign amt[0]  = in_amt;
    assign mode[0] = in_mode;

    for (genvar k = 0; k < AW; k++) begin : g_stage
        lane_rot_stage #(
            .N     (N),
            .W     (W),
            .AW    (AW),
            .LEVEL (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (advance),
            .in_valid  (vld[k]),
            .in_data   (dat[k]),
            .in_amt    (amt[k]),
            .in_mode   (mode[k]),
            .out_valid (vld[k+1]),
            .out_data  (dat[k+1]),
            .out_amt   (amt[k+1]),
            .out_mode  (mode[k+1])
        );
    end

    assign out_valid = vld[AW];
    assign out_data  = dat[AW];

endmodule
